// File: rtl/flop_fifo_rr_arb.sv
// Round-robin drain arbiter: pops one of NUM_REQ flop FIFOs at a time into a
// single tagged output register, with per-requester burst limits and urgency.
module flop_fifo_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned BURST_W = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sync_rst_n,
  input  logic [NUM_REQ*BURST_W-1:0] cfg_burst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_urgent,
  output logic [NUM_REQ-1:0]         req_pop,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [ID_W-1:0]            out_id,
  input  logic                       out_ready,
  output logic                       busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    grant_id_q, last_id_q;
  logic [BURST_W-1:0] burst_cnt_q;

  logic [NUM_REQ-1:0] cand_c;
  logic [ID_W-1:0]    win_id_c, idx_c;
  logic               found_c;
  logic [BURST_W-1:0] burst_cfg_c, burst_load_c;
  logic               pop_ok_c;
  logic               grant_exit_c;

  // Winner search: urgent requesters first, otherwise all valid, starting after last_id.
  always_comb begin
    cand_c   = (|(req_valid & req_urgent)) ? (req_valid & req_urgent) : req_valid;
    win_id_c = '0;
    idx_c    = '0;
    found_c  = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx_c = ID_W'((32'(last_id_q) + k) % NUM_REQ);
      if (!found_c && cand_c[idx_c]) begin
        win_id_c = idx_c;
        found_c  = 1'b1;
      end
    end
  end

  assign burst_cfg_c  = cfg_burst[32'(win_id_c)*BURST_W +: BURST_W];
  assign burst_load_c = (burst_cfg_c == '0) ? BURST_W'(1) : burst_cfg_c;

  // Pops are suppressed while either reset is active so the FIFOs never shift into a clear.
  assign pop_ok_c = (state_q == GRANT) && req_valid[grant_id_q] &&
                    (!out_valid || out_ready) && (burst_cnt_q != '0) &&
                    !rst && sync_rst_n;

  always_comb begin
    req_pop = '0;
    if (pop_ok_c) req_pop[grant_id_q] = 1'b1;
  end

  assign grant_exit_c = (pop_ok_c && (burst_cnt_q == BURST_W'(1))) || !req_valid[grant_id_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req_valid) state_d = GRANT;
      GRANT:   if (grant_exit_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == GRANT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      last_id_q   <= ID_W'(NUM_REQ - 1);
      burst_cnt_q <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_id      <= '0;
    end else if (!sync_rst_n) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      last_id_q   <= ID_W'(NUM_REQ - 1);
      burst_cnt_q <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_id      <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && (|req_valid)) begin
        grant_id_q  <= win_id_c;
        burst_cnt_q <= burst_load_c;
      end
      if (pop_ok_c) begin
        out_data    <= req_data[32'(grant_id_q)*WIDTH +: WIDTH];
        out_id      <= grant_id_q;
        out_valid   <= 1'b1;
        burst_cnt_q <= burst_cnt_q - BURST_W'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if ((state_q == GRANT) && grant_exit_c) last_id_q <= grant_id_q;
    end
  end

endmodule

// File: tb/tb_flop_fifo_rr_arb.sv
// Directed bench for flop_fifo_rr_arb: queue-based FIFO model feeding the arbiter,
// output acceptances logged and compared against hand-computed sequences.
module tb_flop_fifo_rr_arb;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned BW = 4;
  localparam int unsigned IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            sync_rst_n;
  logic [N*BW-1:0] cfg_burst;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_urgent;
  logic [N-1:0]    req_pop;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [IW-1:0]   out_id;
  logic            out_ready;
  logic            busy;

  flop_fifo_rr_arb #(.NUM_REQ(N), .WIDTH(W), .BURST_W(BW), .ID_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .sync_rst_n (sync_rst_n),
    .cfg_burst  (cfg_burst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_urgent (req_urgent),
    .req_pop    (req_pop),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [W-1:0]  fq [N][$];
  logic [IW-1:0] acc_id [$];
  logic [W-1:0]  acc_dat [$];
  int            acc_cyc [$];
  logic [N-1:0]  pop_s;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  int t2_id  [11] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3, 0};
  int t2_dat [11] = '{'h00, 'h01, 'h02, 'h03, 'h10, 'h11, 'h12, 'h20, 'h21, 'h30, 'h04};
  int t3_id  [6]  = '{0, 0, 0, 3, 3, 3};
  int t3_dat [6]  = '{'h00, 'h01, 'h02, 'h30, 'h31, 'h32};
  int t4_dat [8]  = '{'h00, 'h01, 'h02, 'h03, 'h04, 'h05, 'h10, 'h11};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_heads();
    for (int i = 0; i < int'(N); i++) begin
      req_valid[i]       = (fq[i].size() != 0);
      req_data[i*W +: W] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  // One clock: sample pops/acceptances at negedge, then shift the modelled FIFOs.
  task automatic step();
    @(negedge clk);
    pop_s = req_pop;
    if (out_valid && out_ready) begin
      acc_id.push_back(out_id);
      acc_dat.push_back(out_data);
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < int'(N); i++)
      if (pop_s[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    drive_heads();
  endtask

  task automatic clear_acc();
    acc_id.delete();
    acc_dat.delete();
    acc_cyc.delete();
  endtask

  task automatic load(input int i, input int cnt, input int base);
    for (int k = 0; k < cnt; k++) fq[i].push_back(W'(base + k));
  endtask

  task automatic flush();
    for (int i = 0; i < int'(N); i++) fq[i].delete();
    drive_heads();
    sync_rst_n = 1'b0;
    step();
    sync_rst_n = 1'b1;
    clear_acc();
  endtask

  task automatic run_until(input int n, input int max);
    int c;
    c = 0;
    while (acc_id.size() < n && c < max) begin
      step();
      c++;
    end
    check("acc_count", 32'(acc_id.size()), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and single source
    rst = 1'b1; sync_rst_n = 1'b1; out_ready = 1'b1; cfg_burst = 16'h4444;
    req_urgent = '0; req_valid = '0; req_data = '0;
    fq[0].push_back(8'hA1); fq[0].push_back(8'hA2); fq[0].push_back(8'hA3);
    drive_heads();
    repeat (3) begin
      step();
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_pop", 32'(pop_s), 0);
    end
    check("rst_busy", 32'(busy), 0);
    check("rst_out_data", 32'(out_data), 0);
    rst = 1'b0;
    clear_acc();
    run_until(3, 20);
    for (int j = 0; j < 3; j++) begin
      check("t1_data", 32'(acc_dat[j]), 32'('hA1 + j));
      check("t1_id", 32'(acc_id[j]), 0);
    end
    check("t1_consec", 32'(acc_cyc[2] - acc_cyc[0]), 2);
    step(); step();
    check("t1_idle", 32'(busy), 0);

    // Round-robin with bursts {1,2,3,4} for req 3..0
    flush();
    for (int i = 0; i < int'(N); i++) load(i, 8, i * 16);
    cfg_burst = 16'h1234;
    drive_heads();
    run_until(11, 60);
    for (int j = 0; j < 11; j++) begin
      check("t2_id", 32'(acc_id[j]), 32'(t2_id[j]));
      check("t2_data", 32'(acc_dat[j]), 32'(t2_dat[j]));
    end
    for (int j = 1; j < 11; j++)
      check("t2_gap", 32'(acc_cyc[j] - acc_cyc[j-1]),
            (j == 4 || j == 7 || j == 9 || j == 10) ? 2 : 1);

    // Urgency raised mid-burst: current burst completes, then urgent req 3 wins
    flush();
    for (int i = 0; i < int'(N); i++) load(i, 4, i * 16);
    cfg_burst = 16'h3333;
    drive_heads();
    step(); step();
    req_urgent = 4'b1000;
    run_until(6, 40);
    for (int j = 0; j < 6; j++) begin
      check("t3_id", 32'(acc_id[j]), 32'(t3_id[j]));
      check("t3_data", 32'(acc_dat[j]), 32'(t3_dat[j]));
    end
    req_urgent = '0;

    // Backpressure mid-burst
    flush();
    load(0, 6, 'h00);
    load(1, 2, 'h10);
    cfg_burst = 16'h8888;
    drive_heads();
    step(); step(); step();
    check("t4_pre", 32'(out_data), 32'h01);
    out_ready = 1'b0;
    repeat (5) begin
      step();
      check("t4_stall_data", 32'(out_data), 32'h01);
      check("t4_stall_id", 32'(out_id), 0);
      check("t4_stall_valid", 32'(out_valid), 1);
      check("t4_stall_pop", 32'(pop_s), 0);
    end
    out_ready = 1'b1;
    step();
    check("t4_resume", 32'(pop_s), 32'b0001);
    run_until(8, 40);
    for (int j = 0; j < 8; j++) check("t4_data", 32'(acc_dat[j]), 32'(t4_dat[j]));
    check("t4_fq0_empty", 32'(fq[0].size()), 0);
    check("t4_fq1_empty", 32'(fq[1].size()), 0);

    // Burst cfg 0 acts as 1; FIFO empty at grant exits without popping
    flush();
    cfg_burst = 16'h4404;
    load(1, 2, 'h10);
    drive_heads();
    step();
    check("t5_grant", 32'(busy), 1);
    step();
    check("t5_pop", 32'(pop_s), 32'b0010);
    check("t5_limit1", 32'(busy), 0);
    check("t5_out_data", 32'(out_data), 32'h10);
    check("t5_out_id", 32'(out_id), 1);
    check("t5_left", 32'(fq[1].size()), 1);
    step();
    check("t5_regrant", 32'(busy), 1);
    fq[1].delete();
    drive_heads();
    step();
    check("t5_empty_pop", 32'(pop_s), 0);
    check("t5_empty_exit", 32'(busy), 0);
    check("t5_empty_valid", 32'(out_valid), 0);

    // Sync clear mid-burst (last_id is 1 here, so req 2 wins first)
    load(0, 4, 'h00);
    load(2, 4, 'h20);
    cfg_burst = 16'h4444;
    drive_heads();
    step();
    check("t6_grant", 32'(busy), 1);
    step();
    check("t6_out_id", 32'(out_id), 2);
    check("t6_out_data", 32'(out_data), 32'h20);
    sync_rst_n = 1'b0;
    step();
    check("t6_clr_pop", 32'(pop_s), 0);
    check("t6_clr_valid", 32'(out_valid), 0);
    check("t6_clr_idle", 32'(busy), 0);
    sync_rst_n = 1'b1;
    step();
    check("t6_regrant", 32'(busy), 1);
    step();
    check("t6_win0_id", 32'(out_id), 0);
    check("t6_win0_data", 32'(out_data), 32'h00);
    check("t6_win0_valid", 32'(out_valid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/flop_fifo_rr_arb.md
# flop_fifo_rr_arb

Round-robin drain arbiter that shares one downstream valid/ready channel between NUM_REQ shifting flop FIFOs. It sits between a bank of per-source flop FIFOs and a single consumer. Per requester it:
- observes the FIFO head (data_valid/pop_data) and watermark flag;
- issues single-cycle pops;
- forwards each entry through a one-entry output register tagged with the source index.

Per-requester burst limits and watermark-driven urgency give weighted, starvation-free service.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting FIFOs (2..16)
- WIDTH, 8, data width of each FIFO entry
- BURST_W, 4, width of each per-requester burst limit field
- ID_W, $clog2(NUM_REQ), width of out_id

Ports:
- clk  input  1  single clock; all logic on posedge
- rst  input  1  one clock; reset is asynchronous and active-high
- sync_rst_n  input  1  synchronous active-low clear; same effect as rst, applied at posedge
- cfg_burst  input  NUM_REQ*BURST_W  max pops per grant for requester i in bits [i*BURST_W +: BURST_W]; value 0 is treated as 1
- req_valid  input  NUM_REQ  head-of-FIFO valid (FIFO data_valid)
- req_data  input  NUM_REQ*WIDTH  head-of-FIFO data (FIFO pop_data), slice i at [i*WIDTH +: WIDTH]
- req_urgent  input  NUM_REQ  FIFO watermark flag
- req_pop  output  NUM_REQ  one-hot pop to FIFO i; combinational, at most one bit set
- out_valid  output  1  output register holds an entry
- out_data  output  WIDTH  output entry
- out_id  output  ID_W  source index of out_data
- out_ready  input  1  consumer accepts when out_valid && out_ready
- busy  output  1  state == GRANT

## Operation
- State machine with two states, IDLE and GRANT.
- **IDLE**
  - If any req_valid is set, select a winner and move to GRANT.
  - Store grant_id and load burst_cnt = max(cfg_burst[grant_id], 1).
  - Stay in IDLE when no req_valid is set.
- **Winner selection**
  - If any (req_valid & req_urgent) is set, pick round-robin among those only.
  - Otherwise pick round-robin among req_valid.
  - Round-robin search starts at last_id+1 and wraps modulo NUM_REQ.
- **GRANT**
  - pop_ok = req_valid[grant_id] && (!out_valid || out_ready) && burst_cnt != 0.
  - req_pop[grant_id] = pop_ok. On pop_ok:
    - out_data <= req_data slice;
    - out_id <= grant_id;
    - out_valid <= 1;
    - burst_cnt decrements.
  - When out_valid && out_ready with no pop_ok, out_valid <= 0.
  - Exit to IDLE when either:
    - pop_ok and burst_cnt == 1 (burst complete); or
    - !req_valid[grant_id] (FIFO drained; no pop that cycle).
  - On exit, last_id <= grant_id.
  - A stalled consumer (out_ready low with out_valid high) holds GRANT indefinitely. The burst is not aborted.
- The cfg_burst value is sampled only at grant; changes mid-burst take effect on the next grant.
- req_urgent is sampled only in IDLE; urgency never preempts an active grant.
- Reset (rst, or sync_rst_n low) sets:
  - state IDLE; last_id = NUM_REQ-1, so requester 0 wins first;
  - burst_cnt 0; out_valid 0; out_data 0; out_id 0.
- req_pop is forced to 0 while rst is high or sync_rst_n is low.
- rst asserted mid-burst drops any held output entry. The FIFO pop already taken is not replayed.

## Timing
- Arbitration costs one cycle. req_valid seen in IDLE at edge N gives GRANT at N+1; the first req_pop is in cycle N+1; out_valid is first high after edge N+2.
- Within a grant, throughput is 1 pop/cycle while out_ready stays high and the FIFO stays non-empty.
- There is a 1-cycle IDLE bubble between consecutive grants.
- req_pop is same-cycle combinational. The FIFO shifts on the same edge that loads out_data, so the FIFO head must be valid in the pop cycle.
- Worst-case wait for a non-urgent requester while no requester is urgent: (NUM_REQ-1) × (max burst + 1) cycles, plus output stall.

## Test plan
- Reset and single source: rst pulse; req_valid=4'b0001 holding 3 entries (0xA1,0xA2,0xA3); cfg_burst all 4; out_ready=1.
  - Required: out_valid=0 and req_pop=0 during reset.
  - Required: out_data A1,A2,A3 on consecutive cycles with out_id=0, then IDLE.
- Round-robin with burst: all four valid, each 8 deep; cfg_burst={1,2,3,4} for req 3..0.
  - Required: out_id sequence 0,0,0,0,1,1,1,2,2,3,0…
  - Required: exactly one bubble cycle between groups.
- Urgency: req 0..3 valid, last_id=0, req_urgent=4'b1000.
  - Required: next grant goes to 3, not 1.
  - Required: urgent raised mid-burst does not cut the current burst.
- Backpressure: out_ready low for 5 cycles mid-burst.
  - Required: out_data/out_id stable and req_pop=0 for those cycles.
  - Required: pops resume the cycle out_ready returns, with no loss or duplication (scoreboard counts match).
- Drain and cfg zero: cfg_burst[1]=0; req 1 holds 2 entries and goes empty after 1 pop.
  - Required: burst limit 1 is applied.
  - Required: an empty FIFO at grant gives an immediate exit with no pop and no out_valid.
- Sync clear mid-burst: sync_rst_n low for 1 cycle during GRANT.
  - Required: out_valid=0 and state IDLE next cycle.
  - Required: next winner is requester 0.
